operand_wait_queue: RTL and testbench
=====================================

// Module: operand_wait_queue
// PURPOSE
//  Issue-side holding queue between operand selection and the execution units.
//  Accepts issued ops whose operands may still be pending on ROB tags, wakes them up
//  by snooping writeback/commit buses, and dispatches the oldest fully-ready op
//  over an enable/ready handshake. Sequences the operand-select datapath so an op
//  with unresolved TYPE_ROB sources never stalls younger ready ops.
// PARAMETERS
//  DATA       `DataWidth  operand width
//  ROB_DEPTH  `RobDepth   ROB entries; ROB = $clog2(ROB_DEPTH) tag width
//  Q_DEPTH    4           queue entries (>=2)
//  INFO       16          opaque per-op payload width (unit select / opcode)
//  Q = $clog2(Q_DEPTH+1)  occupancy counter width (constant)
// PORTS
//  clk            in   1     clock
//  reset_         in   1     async active-low reset
//  flush_         in   1     sync pipeline flush, active-low
//  issue_e_       in   1     issue request, active-low
//  issue_full     out  1     1 = cannot accept; issue taken iff !issue_e_ && !issue_full
//  issue_rob_id   in   ROB   destination ROB tag of op
//  issue_info     in   INFO  payload, passed through untouched
//  issue_data1    in   DATA  src1 value (valid when issue_data1_e_ == 0)
//  issue_data1_e_ in   1     0 = src1 ready, 1 = waiting on issue_tag1
//  issue_tag1     in   ROB   ROB tag src1 waits on
//  issue_data2/issue_data2_e_/issue_tag2   as src1, for src2
//  wb_e_          in   1     writeback valid, active-low
//  wb_rob_id      in   ROB   writeback tag
//  wb_data        in   DATA  writeback value
//  commit_e_      in   1     commit valid, active-low
//  commit_rob_id  in   ROB   commit tag
//  commit_data    in   DATA  commit value
//  exe_e_         out  1     dispatch valid, active-low
//  exe_ready      in   1     exec unit accepts (active-high)
//  exe_rob_id     out  ROB   dispatched op tag
//  exe_data1      out  DATA  dispatched src1
//  exe_data2      out  DATA  dispatched src2
//  exe_info       out  INFO  dispatched payload
//  occupancy      out  Q     valid entries
// BEHAVIOUR
//  Reset: all entries invalid, occupancy=0, issue_full=0, exe_e_=1, exe_* data = 0.
//  Storage: shift-compacting queue, entry 0 oldest; valid entries contiguous from 0.
//  Entry: valid, rob_id, info, per src {rdy, tag, data}.
//  issue_full = (occupancy == Q_DEPTH), from registered state only; no
//   accept-while-dispatch when full (issue retried next cycle).
//  Select (comb): lowest index with valid && rdy1 && rdy2; exe_e_=0 and exe_* driven
//   from it; none -> exe_e_=1, exe_* = 0.
//  Dispatch at edge where !exe_e_ && exe_ready: entry removed, younger entries shift
//   down one, preserving order. exe_ready while exe_e_=1 is ignored.
//  Wakeup (registered): per waiting src, tag match on !wb_e_ sets rdy, data=wb_data;
//   else match on !commit_e_ sets rdy, data=commit_data. Both match -> wb wins.
//   Woken src dispatchable earliest next cycle (no same-cycle bypass to exe_*).
//  Issue capture: new entry written at index occupancy (after shift if same-cycle
//   dispatch); waiting srcs also snoop wb/commit in the issue cycle, so a tag
//   broadcast coincident with issue is never lost.
//  Simultaneous issue+dispatch (not full): occupancy unchanged, order preserved.
//  Flush (!flush_): all valid cleared next edge, same-cycle issue and dispatch dropped
//   (exe_ready ignored); flush dominates all. Async reset mid-op: immediate clear.
//  occupancy never exceeds Q_DEPTH nor underflows; assertion on both.
// TESTING
//  1 Issue ready op (data1=5,data2=7,rob=3), exe_ready=1 -> exe_e_=0 next cycle,
//    exe_data1=5, exe_data2=7, exe_rob_id=3; occupancy 1->0 after edge.
//  2 Issue op A src1 waits tag 9, then ready op B -> B dispatched first; wb tag 9
//    data=0xAA -> A dispatched following cycle with exe_data1=0xAA.
//  3 Fill Q_DEPTH waiting ops -> issue_full=1, extra issue ignored; dispatch one with
//    same-cycle issue -> issue still rejected, accepted next cycle.
//  4 wb tag 4 (data 0x11) and commit tag 4 (data 0x22) same cycle as issue waiting
//    on tag 4 -> entry ready next cycle with data 0x11.
//  5 Two ready entries, exe_ready=0 for 3 cycles -> exe_* held stable on oldest;
//    then exe_ready=1 -> order oldest then younger.
//  6 flush_=0 with 3 entries and concurrent issue+exe_ready -> occupancy=0,
//    exe_e_=1 next cycle, nothing dispatched; reset_ mid-op -> outputs at reset values.

Source files
------------

// File: rtl/operand_wait_queue_if.sv
// Issue, wakeup-broadcast and dispatch signals of the operand wait queue.
// The queue side uses modport slave; the producer/consumer side uses modport master.
interface operand_wait_queue_if #(
  parameter int DATA = 32,
  parameter int ROB  = 4,
  parameter int INFO = 16,
  parameter int Q    = 3
);
  logic            issue_e_;
  logic            issue_full;
  logic [ROB-1:0]  issue_rob_id;
  logic [INFO-1:0] issue_info;
  logic [DATA-1:0] issue_data1;
  logic            issue_data1_e_;
  logic [ROB-1:0]  issue_tag1;
  logic [DATA-1:0] issue_data2;
  logic            issue_data2_e_;
  logic [ROB-1:0]  issue_tag2;
  logic            wb_e_;
  logic [ROB-1:0]  wb_rob_id;
  logic [DATA-1:0] wb_data;
  logic            commit_e_;
  logic [ROB-1:0]  commit_rob_id;
  logic [DATA-1:0] commit_data;
  logic            exe_e_;
  logic            exe_ready;
  logic [ROB-1:0]  exe_rob_id;
  logic [DATA-1:0] exe_data1;
  logic [DATA-1:0] exe_data2;
  logic [INFO-1:0] exe_info;
  logic [Q-1:0]    occupancy;

  modport master (
    output issue_e_, issue_rob_id, issue_info,
           issue_data1, issue_data1_e_, issue_tag1,
           issue_data2, issue_data2_e_, issue_tag2,
           wb_e_, wb_rob_id, wb_data,
           commit_e_, commit_rob_id, commit_data, exe_ready,
    input  issue_full, exe_e_, exe_rob_id, exe_data1, exe_data2, exe_info, occupancy
  );

  modport slave (
    input  issue_e_, issue_rob_id, issue_info,
           issue_data1, issue_data1_e_, issue_tag1,
           issue_data2, issue_data2_e_, issue_tag2,
           wb_e_, wb_rob_id, wb_data,
           commit_e_, commit_rob_id, commit_data, exe_ready,
    output issue_full, exe_e_, exe_rob_id, exe_data1, exe_data2, exe_info, occupancy
  );
endinterface

// File: rtl/operand_wait_queue.sv
// Shift-compacting issue queue: ops wait on ROB tags, wake from wb/commit broadcasts,
// and the oldest fully-ready op is offered on exe_* (select is combinational from state).
module operand_wait_queue #(
  parameter int DATA      = 32,
  parameter int ROB_DEPTH = 16,
  parameter int Q_DEPTH   = 4,
  parameter int INFO      = 16
) (
  input logic                 clk,
  input logic                 reset_,
  input logic                 flush_,
  operand_wait_queue_if.slave bus
);
  localparam int ROB = $clog2(ROB_DEPTH);
  localparam int Q   = $clog2(Q_DEPTH + 1);
  localparam int IDX = $clog2(Q_DEPTH);

  typedef struct packed {
    logic            rdy;
    logic [ROB-1:0]  tag;
    logic [DATA-1:0] data;
  } src_t;

  typedef struct packed {
    logic            vld;
    logic [ROB-1:0]  rob_id;
    logic [INFO-1:0] info;
    src_t            s1;
    src_t            s2;
  } entry_t;

  entry_t         q     [Q_DEPTH];
  entry_t         q_nxt [Q_DEPTH];
  entry_t         woke  [Q_DEPTH];
  entry_t         new_ent;
  logic [Q-1:0]   occ;
  logic [Q-1:0]   occ_nxt;
  logic [Q-1:0]   wr_pos;
  logic           sel_found;
  logic [IDX-1:0] sel_idx;
  logic           dispatch;
  logic           accept;

  // wb has priority over commit when both carry the awaited tag
  function automatic src_t snoop(input src_t s);
    src_t r;
    r = s;
    if (!s.rdy) begin
      if (!bus.wb_e_ && bus.wb_rob_id == s.tag) begin
        r.rdy  = 1'b1;
        r.data = bus.wb_data;
      end else if (!bus.commit_e_ && bus.commit_rob_id == s.tag) begin
        r.rdy  = 1'b1;
        r.data = bus.commit_data;
      end
    end
    return r;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = Q_DEPTH - 1; i >= 0; i--) begin
      if (q[i].vld && q[i].s1.rdy && q[i].s2.rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX'(i);
      end
    end
  end

  assign bus.issue_full = (occ == Q'(Q_DEPTH));
  assign bus.occupancy  = occ;
  assign accept         = !bus.issue_e_ && !bus.issue_full && flush_;
  assign dispatch       = sel_found && bus.exe_ready && flush_;

  always_comb begin
    bus.exe_e_     = !sel_found;
    bus.exe_rob_id = '0;
    bus.exe_data1  = '0;
    bus.exe_data2  = '0;
    bus.exe_info   = '0;
    if (sel_found) begin
      bus.exe_rob_id = q[sel_idx].rob_id;
      bus.exe_data1  = q[sel_idx].s1.data;
      bus.exe_data2  = q[sel_idx].s2.data;
      bus.exe_info   = q[sel_idx].info;
    end
  end

  always_comb begin
    for (int i = 0; i < Q_DEPTH; i++) begin
      woke[i]    = q[i];
      woke[i].s1 = snoop(q[i].s1);
      woke[i].s2 = snoop(q[i].s2);
    end
    q_nxt = woke;
    // remove the dispatched entry and slide everything younger down one slot
    if (dispatch) begin
      for (int i = 0; i < Q_DEPTH - 1; i++) begin
        if (IDX'(i) >= sel_idx) q_nxt[i] = woke[i + 1];
      end
      q_nxt[Q_DEPTH - 1] = '0;
    end
    new_ent         = '0;
    new_ent.vld     = 1'b1;
    new_ent.rob_id  = bus.issue_rob_id;
    new_ent.info    = bus.issue_info;
    new_ent.s1.rdy  = !bus.issue_data1_e_;
    new_ent.s1.tag  = bus.issue_tag1;
    new_ent.s1.data = bus.issue_data1;
    new_ent.s2.rdy  = !bus.issue_data2_e_;
    new_ent.s2.tag  = bus.issue_tag2;
    new_ent.s2.data = bus.issue_data2;
    new_ent.s1      = snoop(new_ent.s1);
    new_ent.s2      = snoop(new_ent.s2);
    wr_pos  = occ - Q'(dispatch);
    if (accept) q_nxt[wr_pos[IDX-1:0]] = new_ent;
    occ_nxt = occ - Q'(dispatch) + Q'(accept);
    if (!flush_) begin
      for (int i = 0; i < Q_DEPTH; i++) q_nxt[i] = '0;
      occ_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < Q_DEPTH; i++) q[i] <= '0;
      occ <= '0;
    end else begin
      q   <= q_nxt;
      occ <= occ_nxt;
    end
  end

  occ_no_overflow: assert property (@(posedge clk) disable iff (!reset_) occ <= Q'(Q_DEPTH));
  occ_no_underflow: assert property (@(posedge clk) disable iff (!reset_) (occ != '0) || !dispatch);
endmodule

// File: tb/tb_operand_wait_queue.sv
// Directed scenarios followed by random traffic, compared each cycle against a queue-level model.
module tb_operand_wait_queue;
  localparam int QD = 4;

  logic clk    = 1'b0;
  logic reset_ = 1'b0;
  logic flush_ = 1'b1;
  always #5 clk = ~clk;

  operand_wait_queue_if bus ();
  operand_wait_queue dut (.clk(clk), .reset_(reset_), .flush_(flush_), .bus(bus));

  typedef struct {
    logic [3:0]  rob;
    logic [15:0] info;
    bit          r1;
    logic [3:0]  t1;
    logic [31:0] d1;
    bit          r2;
    logic [3:0]  t2;
    logic [31:0] d2;
  } op_t;

  op_t mq[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] bcast(input logic [3:0] t);
    if (!bus.wb_e_ && bus.wb_rob_id == t) return {1'b1, bus.wb_data};
    if (!bus.commit_e_ && bus.commit_rob_id == t) return {1'b1, bus.commit_data};
    return '0;
  endfunction

  function automatic op_t wake_op(input op_t o);
    op_t n;
    logic [32:0] h;
    n = o;
    h = bcast(n.t1);
    if (!n.r1 && h[32]) begin n.r1 = 1'b1; n.d1 = h[31:0]; end
    h = bcast(n.t2);
    if (!n.r2 && h[32]) begin n.r2 = 1'b1; n.d2 = h[31:0]; end
    return n;
  endfunction

  function automatic int first_ready();
    foreach (mq[i]) if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // check outputs against the model, advance the model with the driven inputs, then clock
  task automatic cycle();
    int  fr;
    bit  was_full;
    op_t n;
    #1;
    fr = first_ready();
    chk("occupancy", bus.occupancy, mq.size());
    chk("issue_full", bus.issue_full, mq.size() == QD);
    chk("exe_e_", bus.exe_e_, fr < 0);
    if (fr < 0) begin
      chk("idle_rob", bus.exe_rob_id, 0);
      chk("idle_data1", bus.exe_data1, 0);
      chk("idle_data2", bus.exe_data2, 0);
      chk("idle_info", bus.exe_info, 0);
    end else begin
      chk("exe_rob_id", bus.exe_rob_id, mq[fr].rob);
      chk("exe_data1", bus.exe_data1, mq[fr].d1);
      chk("exe_data2", bus.exe_data2, mq[fr].d2);
      chk("exe_info", bus.exe_info, mq[fr].info);
    end
    was_full = (mq.size() == QD);
    if (!flush_) mq.delete();
    else begin
      if (fr >= 0 && bus.exe_ready) mq.delete(fr);
      foreach (mq[i]) mq[i] = wake_op(mq[i]);
      if (!bus.issue_e_ && !was_full) begin
        n.rob  = bus.issue_rob_id;
        n.info = bus.issue_info;
        n.r1   = !bus.issue_data1_e_;
        n.t1   = bus.issue_tag1;
        n.d1   = bus.issue_data1;
        n.r2   = !bus.issue_data2_e_;
        n.t2   = bus.issue_tag2;
        n.d2   = bus.issue_data2;
        mq.push_back(wake_op(n));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.issue_e_   = 1'b1;
    bus.wb_e_      = 1'b1;
    bus.commit_e_  = 1'b1;
    bus.exe_ready  = 1'b0;
    flush_         = 1'b1;
  endtask

  task automatic drive_issue(input logic [3:0] rob, input bit w1, input logic [3:0] t1,
                             input logic [31:0] d1, input bit w2, input logic [3:0] t2,
                             input logic [31:0] d2);
    bus.issue_e_       = 1'b0;
    bus.issue_rob_id   = rob;
    bus.issue_info     = {12'hA5C, rob};
    bus.issue_data1_e_ = w1;
    bus.issue_tag1     = t1;
    bus.issue_data1    = d1;
    bus.issue_data2_e_ = w2;
    bus.issue_tag2     = t2;
    bus.issue_data2    = d2;
  endtask

  task automatic wb(input logic [3:0] t, input logic [31:0] d);
    bus.wb_e_     = 1'b0;
    bus.wb_rob_id = t;
    bus.wb_data   = d;
  endtask

  initial begin
    idle();
    drive_issue(0, 0, 0, 0, 0, 0, 0);
    bus.issue_e_      = 1'b1;
    bus.wb_rob_id     = '0;
    bus.wb_data       = '0;
    bus.commit_rob_id = '0;
    bus.commit_data   = '0;
    repeat (2) @(negedge clk);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_full", bus.issue_full, 0);
    chk("rst_exe_e_", bus.exe_e_, 1);
    chk("rst_data1", bus.exe_data1, 0);
    reset_ = 1'b1;
    @(negedge clk);

    // ready op dispatched the cycle after issue
    drive_issue(3, 0, 0, 5, 0, 0, 7);
    bus.exe_ready = 1'b1;
    cycle();
    bus.issue_e_ = 1'b1;
    chk("t1_exe_e_", bus.exe_e_, 0);
    chk("t1_data1", bus.exe_data1, 5);
    chk("t1_data2", bus.exe_data2, 7);
    chk("t1_rob", bus.exe_rob_id, 3);
    cycle();
    chk("t1_occ", bus.occupancy, 0);

    // younger ready op overtakes older waiting op
    idle();
    drive_issue(1, 1, 9, 0, 0, 0, 2);
    cycle();
    drive_issue(2, 0, 0, 3, 0, 0, 4);
    cycle();
    idle();
    chk("t2_b_first", bus.exe_rob_id, 2);
    bus.exe_ready = 1'b1;
    cycle();
    chk("t2_a_waiting", bus.exe_e_, 1);
    wb(9, 32'hAA);
    cycle();
    bus.wb_e_ = 1'b1;
    chk("t2_a_ready", bus.exe_e_, 0);
    chk("t2_a_data1", bus.exe_data1, 32'hAA);
    chk("t2_a_rob", bus.exe_rob_id, 1);
    cycle();
    chk("t2_occ", bus.occupancy, 0);

    // full queue rejects issue, even with same-cycle dispatch
    idle();
    for (int i = 0; i < QD; i++) begin
      drive_issue(4'(8 + i), 1, 4'(10 + i), 0, 0, 0, 1);
      cycle();
    end
    chk("t3_full", bus.issue_full, 1);
    drive_issue(12, 0, 0, 1, 0, 0, 1);
    cycle();
    chk("t3_rejected", bus.occupancy, QD);
    idle();
    wb(10, 32'h10);
    cycle();
    idle();
    drive_issue(13, 0, 0, 6, 0, 0, 6);
    bus.exe_ready = 1'b1;
    cycle();
    chk("t3_no_bypass", bus.occupancy, QD - 1);
    bus.exe_ready = 1'b0;
    cycle();
    chk("t3_retry", bus.occupancy, QD);
    idle();
    bus.exe_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb(4'(11 + k), 32'(k + 100));
      cycle();
    end
    bus.wb_e_ = 1'b1;
    repeat (4) cycle();
    chk("t3_drained", bus.occupancy, 0);

    // wb beats commit on the same tag, coincident with issue
    idle();
    drive_issue(5, 1, 4, 0, 0, 0, 9);
    wb(4, 32'h11);
    bus.commit_e_     = 1'b0;
    bus.commit_rob_id = 4;
    bus.commit_data   = 32'h22;
    cycle();
    idle();
    chk("t4_ready", bus.exe_e_, 0);
    chk("t4_wb_wins", bus.exe_data1, 32'h11);
    bus.exe_ready = 1'b1;
    cycle();
    chk("t4_occ", bus.occupancy, 0);

    // backpressure holds the oldest op stable
    idle();
    drive_issue(5, 0, 0, 1, 0, 0, 2);
    cycle();
    drive_issue(6, 0, 0, 3, 0, 0, 4);
    cycle();
    idle();
    repeat (3) begin
      chk("t5_hold_rob", bus.exe_rob_id, 5);
      chk("t5_hold_data", bus.exe_data1, 1);
      cycle();
    end
    bus.exe_ready = 1'b1;
    cycle();
    chk("t5_second", bus.exe_rob_id, 6);
    cycle();
    chk("t5_empty", bus.exe_e_, 1);

    // flush with concurrent issue and dispatch, then async reset mid-op
    idle();
    for (int i = 1; i <= 3; i++) begin
      drive_issue(4'(i), 0, 0, 32'(i), 0, 0, 32'(i));
      cycle();
    end
    drive_issue(4, 0, 0, 4, 0, 0, 4);
    bus.exe_ready = 1'b1;
    flush_ = 1'b0;
    cycle();
    idle();
    chk("t6_flush_occ", bus.occupancy, 0);
    chk("t6_flush_exe", bus.exe_e_, 1);
    drive_issue(7, 0, 0, 8, 0, 0, 9);
    cycle();
    drive_issue(8, 1, 3, 0, 0, 0, 9);
    cycle();
    idle();
    #2 reset_ = 1'b0;
    #1;
    mq.delete();
    chk("t6_rst_occ", bus.occupancy, 0);
    chk("t6_rst_exe", bus.exe_e_, 1);
    chk("t6_rst_full", bus.issue_full, 0);
    chk("t6_rst_rob", bus.exe_rob_id, 0);
    chk("t6_rst_data1", bus.exe_data1, 0);
    @(negedge clk);
    reset_ = 1'b1;
    @(negedge clk);

    // random traffic against the model
    repeat (500) begin
      bus.issue_e_       = ($urandom_range(0, 2) == 0);
      bus.issue_rob_id   = 4'($urandom_range(0, 15));
      bus.issue_info     = 16'($urandom);
      bus.issue_data1_e_ = ($urandom_range(0, 2) == 0);
      bus.issue_tag1     = 4'($urandom_range(0, 15));
      bus.issue_data1    = $urandom;
      bus.issue_data2_e_ = ($urandom_range(0, 2) == 0);
      bus.issue_tag2     = 4'($urandom_range(0, 15));
      bus.issue_data2    = $urandom;
      bus.wb_e_          = ($urandom_range(0, 1) == 0);
      bus.wb_rob_id      = 4'($urandom_range(0, 15));
      bus.wb_data        = $urandom;
      bus.commit_e_      = ($urandom_range(0, 2) != 0);
      bus.commit_rob_id  = 4'($urandom_range(0, 15));
      bus.commit_data    = $urandom;
      bus.exe_ready      = ($urandom_range(0, 3) != 0);
      flush_             = ($urandom_range(0, 40) != 0);
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
